// File: rtl/v30mz_pkg.sv
// Shared writeback types: register-file write part encoding, the
// normalised writeback entry, and the 8086 byte-register mapping helper.
package v30mz_pkg;

   localparam int unsigned WB_CODE_W = 3;
   localparam int unsigned WB_DATA_W = 16;

   typedef enum logic [1:0] {
      PART_NONE = 2'b00,
      PART_LO   = 2'b01,
      PART_HI   = 2'b10,
      PART_WORD = 2'b11
   } wb_part_t;

   typedef struct packed {
      logic [WB_CODE_W-1:0] id;
      wb_part_t             part;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

   // AL..BL (0..3) map to the low byte of word regs 0..3;
   // AH..BH (4..7) map to the high byte of the same word regs.
   function automatic wb_entry_t byte_reg_map(input logic [WB_CODE_W-1:0] code,
                                              input logic                 is_byte,
                                              input logic [WB_DATA_W-1:0] data);
      wb_entry_t e;
      if (!is_byte) begin
         e.id   = code;
         e.part = PART_WORD;
         e.data = data;
      end else if (!code[2]) begin
         e.id   = code;
         e.part = PART_LO;
         e.data = {8'h00, data[7:0]};
      end else begin
         e.id   = {1'b0, code[1:0]};
         e.part = PART_HI;
         e.data = {data[7:0], 8'h00};
      end
      return e;
   endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: writeback entry FIFO with two write ports (second only used
// together with the first, for dual-destination results) and one read
// port. Exposes the occupancy and per-slot valid/id for hazard tracking.
module wb_fifo
   import v30mz_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr0_en_i,
   input  wb_entry_t                         wr0_entry_i,
   input  logic                              wr1_en_i,
   input  wb_entry_t                         wr1_entry_i,
   input  logic                              rd_en_i,
   output wb_entry_t                         head_o,
   output logic [$clog2(DEPTH):0]            count_o,
   output logic [DEPTH-1:0]                  vld_o,
   output logic [DEPTH-1:0][WB_CODE_W-1:0]   id_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   wb_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_ptr_nx;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q, vld_d;

   // Next-state for pointers, occupancy and per-slot valid bits
   always_comb begin
      wr_ptr_nx = wr_ptr_q + PW'(1);
      wr_ptr_d  = wr_ptr_q + PW'(wr0_en_i) + PW'(wr1_en_i);
      rd_ptr_d  = rd_ptr_q + PW'(rd_en_i);
      count_d   = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
      vld_d     = vld_q;
      if (rd_en_i)  vld_d[rd_ptr_q]  = 1'b0;
      if (wr0_en_i) vld_d[wr_ptr_q]  = 1'b1;
      if (wr1_en_i) vld_d[wr_ptr_nx] = 1'b1;
   end

   // Control state register; reset discards all queued entries
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
      end
   end

   // Entry storage; contents are qualified by vld_q/count_q so no reset
   always_ff @(posedge clk) begin
      if (wr0_en_i) mem_q[wr_ptr_q]  <= wr0_entry_i;
      if (wr1_en_i) mem_q[wr_ptr_nx] <= wr1_entry_i;
   end

   // Per-slot destination ids for the pending mask
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         id_o[i] = mem_q[i].id;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign vld_o   = vld_q;

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage ahead of the register file. Arbitrates
// load (priority) and execute results, normalises byte-register codes,
// queues entries in wb_fifo and drains one write per cycle.
// Optional feature: REG_WB_BYPASS_EN lets the first entry of a request
// accepted into an empty FIFO go straight to the register-file port.
module reg_writeback
   import v30mz_pkg::*;
#(
   parameter int unsigned NUM_REGISTERS = 8,
   parameter int unsigned DEPTH         = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             mem_valid,
   output logic                             mem_ready,
   input  logic                             mem_byte,
   input  logic [2:0]                       mem_id,
   input  logic [15:0]                      mem_data,
   input  logic                             exec_valid,
   output logic                             exec_ready,
   input  logic                             exec_byte,
   input  logic                             exec_dual,
   input  logic [2:0]                       exec_id,
   input  logic [15:0]                      exec_data,
   input  logic [2:0]                       exec_id2,
   input  logic [15:0]                      exec_data2,
   output logic                             we,
   output logic [1:0]                       write_part,
   output logic [$clog2(NUM_REGISTERS)-1:0] write_id,
   output logic [15:0]                      write_data,
   output logic [NUM_REGISTERS-1:0]         pending
);

   localparam int unsigned IDW = $clog2(NUM_REGISTERS);
   localparam int unsigned CW  = $clog2(DEPTH) + 1;

   logic [CW-1:0]                  count, free;
   logic                           mem_fire, exec_fire, any_fire, dual_fire, deq;
   logic                           wr0_en, wr1_en;
   wb_entry_t                      e0, e1, wr0_entry, wr1_entry, head, out_entry;
   logic [DEPTH-1:0]               fifo_vld;
   logic [DEPTH-1:0][WB_CODE_W-1:0] fifo_id;
`ifdef REG_WB_BYPASS_EN
   logic                           bypass;
`endif

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr0_en_i    (wr0_en),
      .wr0_entry_i (wr0_entry),
      .wr1_en_i    (wr1_en),
      .wr1_entry_i (wr1_entry),
      .rd_en_i     (deq),
      .head_o      (head),
      .count_o     (count),
      .vld_o       (fifo_vld),
      .id_o        (fifo_id)
   );

   // Space check uses current occupancy only; a same-cycle drain never adds room
   always_comb begin
      free       = CW'(DEPTH) - count;
      mem_ready  = (free >= CW'(1));
      exec_ready = !mem_valid && (free >= (exec_dual ? CW'(2) : CW'(1)));
      mem_fire   = mem_valid && mem_ready;
      exec_fire  = exec_valid && exec_ready;
      any_fire   = mem_fire || exec_fire;
      dual_fire  = exec_fire && exec_dual;
      deq        = (count != '0);
   end

   // Normalise the winning request into one or two entries
   always_comb begin
      e0 = mem_fire ? byte_reg_map(mem_id, mem_byte, mem_data)
                    : byte_reg_map(exec_id, exec_byte, exec_data);
      e1 = byte_reg_map(exec_id2, exec_byte, exec_data2);
   end

`ifdef REG_WB_BYPASS_EN
   assign bypass = any_fire && (count == '0);
`endif

   // Enqueue steering; a bypassed first entry shifts the second onto port 0
   always_comb begin
      wr0_en    = any_fire;
      wr0_entry = e0;
      wr1_en    = dual_fire;
      wr1_entry = e1;
`ifdef REG_WB_BYPASS_EN
      if (bypass) begin
         wr0_en    = dual_fire;
         wr0_entry = e1;
         wr1_en    = 1'b0;
      end
`endif
   end

   // Register-file port: FIFO head, or the bypassed entry, else all zero
   always_comb begin
      we        = 1'b0;
      out_entry = '0;
`ifdef REG_WB_BYPASS_EN
      if (bypass) begin
         we        = 1'b1;
         out_entry = e0;
      end else
`endif
      if (deq) begin
         we        = 1'b1;
         out_entry = head;
      end
   end

   assign write_part = out_entry.part;
   assign write_id   = IDW'(out_entry.id);
   assign write_data = out_entry.data;

   // Pending mask: OR of one-hot destinations of all valid FIFO slots
   always_comb begin
      pending = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (fifo_vld[i]) pending[fifo_id[i]] = 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a write scoreboard; expected
// latencies follow REG_WB_BYPASS_EN when it is defined for the build.
module tb_reg_writeback;

   logic        clk;
   logic        reset;
   logic        mem_valid, mem_ready, mem_byte;
   logic [2:0]  mem_id;
   logic [15:0] mem_data;
   logic        exec_valid, exec_ready, exec_byte, exec_dual;
   logic [2:0]  exec_id, exec_id2;
   logic [15:0] exec_data, exec_data2;
   logic        we;
   logic [1:0]  write_part;
   logic [2:0]  write_id;
   logic [15:0] write_data;
   logic [7:0]  pending;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [20:0] sb[$];

`ifdef REG_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
   localparam int NDUAL = 3;
`else
   localparam bit BYP = 1'b0;
   localparam int NDUAL = 2;
`endif

   reg_writeback #(.NUM_REGISTERS(8), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_byte   (mem_byte),
      .mem_id     (mem_id),
      .mem_data   (mem_data),
      .exec_valid (exec_valid),
      .exec_ready (exec_ready),
      .exec_byte  (exec_byte),
      .exec_dual  (exec_dual),
      .exec_id    (exec_id),
      .exec_data  (exec_data),
      .exec_id2   (exec_id2),
      .exec_data2 (exec_data2),
      .we         (we),
      .write_part (write_part),
      .write_id   (write_id),
      .write_data (write_data),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {id, part, data} for a destination code
   function automatic logic [20:0] exp_map(input logic [2:0] c, input logic b, input logic [15:0] d);
      if (!b)          return {c, 2'b11, d};
      else if (c < 3'd4) return {c, 2'b01, 8'h00, d[7:0]};
      else             return {c - 3'd4, 2'b10, d[7:0], 8'h00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; holds the request until accepted (bounded)
   task automatic mem_put(input logic [2:0] id, input logic b, input logic [15:0] d);
      mem_valid = 1'b1; mem_id = id; mem_byte = b; mem_data = d;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_ready) begin
            sb.push_back(exp_map(id, b, d));
            @(posedge clk); #1;
            mem_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("mem_accept_timeout", 32'd0, 32'd1);
      mem_valid = 1'b0;
   endtask

   task automatic exec_put(input logic [2:0] id, input logic [2:0] id2, input logic b,
                           input logic dual, input logic [15:0] d, input logic [15:0] d2);
      exec_valid = 1'b1; exec_id = id; exec_id2 = id2; exec_byte = b; exec_dual = dual;
      exec_data = d; exec_data2 = d2;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (exec_ready) begin
            sb.push_back(exp_map(id, b, d));
            if (dual) sb.push_back(exp_map(id2, b, d2));
            @(posedge clk); #1;
            exec_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      chk("exec_accept_timeout", 32'd0, 32'd1);
      exec_valid = 1'b0;
   endtask

   // Scoreboard: every register-file write must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && we) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $error("FAIL unexpected_write observed=%h expected=none", {write_id, write_part, write_data});
         end else begin
            logic [20:0] e;
            e = sb.pop_front();
            assert ({write_id, write_part, write_data} === e) else begin
               bad++;
               $error("FAIL write observed=%h expected=%h", {write_id, write_part, write_data}, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      mem_valid = 1'b0; mem_byte = 1'b0; mem_id = '0; mem_data = '0;
      exec_valid = 1'b0; exec_byte = 1'b0; exec_dual = 1'b0;
      exec_id = '0; exec_id2 = '0; exec_data = '0; exec_data2 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_we",      32'(we), 32'd0);
      chk("rst_fields",  32'({write_id, write_part, write_data}), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_mem_rdy", 32'(mem_ready), 32'd1);
      chk("rst_exe_rdy", 32'(exec_ready), 32'd1);
      #1;

      // 1: byte write to CH lands in high byte of word reg 1
      mem_put(3'd5, 1'b1, 16'h00AB);
      #1;
      chk("t1_we",     32'(we), BYP ? 32'd0 : 32'd1);
      chk("t1_fields", 32'({write_id, write_part, write_data}),
          BYP ? 32'd0 : 32'({3'd1, 2'b10, 16'hAB00}));
      idle(3);

      // Low-byte mapping and same-register byte pair via exec dual
      mem_put(3'd2, 1'b1, 16'h12CD);
      exec_put(3'd0, 3'd4, 1'b1, 1'b1, 16'hFF11, 16'hEE22);
      idle(4);

      // 2: exec dual word, pending mask evolution
      exec_put(3'd0, 3'd2, 1'b0, 1'b1, 16'h1234, 16'h5678);
      #1;
      chk("t2_pend0", 32'(pending), BYP ? 32'h04 : 32'h05);
      @(posedge clk); #2;
      chk("t2_pend1", 32'(pending), BYP ? 32'h00 : 32'h04);
      @(posedge clk); #2;
      chk("t2_pend2", 32'(pending), 32'h00);
      idle(3);

      // 3: mem has priority; exec accepted once mem_valid drops
      mem_valid = 1'b1; mem_byte = 1'b0; mem_id = 3'd6; mem_data = 16'h6666;
      exec_valid = 1'b1; exec_byte = 1'b0; exec_dual = 1'b0; exec_id = 3'd4; exec_data = 16'h4444;
      #1;
      chk("t3_mem_rdy", 32'(mem_ready), 32'd1);
      chk("t3_exe_rdy", 32'(exec_ready), 32'd0);
      sb.push_back(exp_map(3'd6, 1'b0, 16'h6666));
      @(posedge clk); #1;
      mem_valid = 1'b0;
      #1;
      chk("t3_exe_rdy2", 32'(exec_ready), 32'd1);
      if (exec_ready) sb.push_back(exp_map(3'd4, 1'b0, 16'h4444));
      @(posedge clk); #1;
      exec_valid = 1'b0;
      idle(4);

      // Last accepted write to a register drains last
      mem_put(3'd7, 1'b0, 16'h0001);
      mem_put(3'd7, 1'b0, 16'h0002);
      idle(4);

      // 4: back-to-back dual exec until space runs out, then a single fits
      exec_valid = 1'b1; exec_dual = 1'b1; exec_byte = 1'b0;
      for (int k = 0; k <= NDUAL; k++) begin
         exec_id = 3'(k); exec_id2 = 3'(k + 4);
         exec_data = 16'hA000 + 16'(k); exec_data2 = 16'hB000 + 16'(k);
         #1;
         chk("t4_dual_rdy", 32'(exec_ready), (k < NDUAL) ? 32'd1 : 32'd0);
         if (exec_ready) begin
            sb.push_back(exp_map(exec_id, 1'b0, exec_data));
            sb.push_back(exp_map(exec_id2, 1'b0, exec_data2));
            @(posedge clk); #1;
         end
      end
      exec_dual = 1'b0; exec_id = 3'd7; exec_data = 16'h7777;
      #1;
      chk("t4_single_rdy", 32'(exec_ready), 32'd1);
      chk("t4_mem_rdy",    32'(mem_ready), 32'd1);
      if (exec_ready) sb.push_back(exp_map(3'd7, 1'b0, 16'h7777));
      @(posedge clk); #1;
      exec_valid = 1'b0;
      idle(8);
      chk("t4_drained", 32'(sb.size()), 32'd0);

      // 5: reset with three entries queued discards them
      exec_valid = 1'b1; exec_dual = 1'b1; exec_byte = 1'b0;
      for (int k = 0; k < NDUAL; k++) begin
         exec_id = 3'(k + 1); exec_id2 = 3'(k + 5);
         exec_data = 16'hC000 + 16'(k); exec_data2 = 16'hD000 + 16'(k);
         #1;
         if (exec_ready) begin
            sb.push_back(exp_map(exec_id, 1'b0, exec_data));
            sb.push_back(exp_map(exec_id2, 1'b0, exec_data2));
         end
         @(posedge clk); #1;
      end
      #1;
      chk("t5_full_rdy", 32'(exec_ready), 32'd0);
      reset = 1'b1; exec_valid = 1'b0; exec_dual = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("t5_we",      32'(we), 32'd0);
      chk("t5_pending", 32'(pending), 32'd0);
      chk("t5_mem_rdy", 32'(mem_ready), 32'd1);
      chk("t5_fields",  32'({write_id, write_part, write_data}), 32'd0);
      idle(5);

      // 6: word write code 3 to empty FIFO; bypass shifts it one cycle earlier
      mem_valid = 1'b1; mem_byte = 1'b0; mem_id = 3'd3; mem_data = 16'hBEEF;
      #1;
      chk("t6_rdy", 32'(mem_ready), 32'd1);
      chk("t6_we0", 32'(we), BYP ? 32'd1 : 32'd0);
      chk("t6_f0",  32'({write_id, write_part, write_data}),
          BYP ? 32'({3'd3, 2'b11, 16'hBEEF}) : 32'd0);
      sb.push_back(exp_map(3'd3, 1'b0, 16'hBEEF));
      @(posedge clk); #1;
      mem_valid = 1'b0;
      #1;
      chk("t6_we1", 32'(we), BYP ? 32'd0 : 32'd1);
      chk("t6_f1",  32'({write_id, write_part, write_data}),
          BYP ? 32'd0 : 32'({3'd3, 2'b11, 16'hBEEF}));
      idle(6);

      chk("final_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
